// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state encoding and trap cause codes.
// Imported by the sequencer, ALU and register file.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_ILLEGAL    = 2'd2,
    CAUSE_TIMEOUT    = 2'd3
  } cause_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/core_sequencer_bus_watchdog.sv
// Counts bus wait cycles and flags an access that has stalled past the limit.
// A ready on the limit cycle still completes, so expiry requires ready low.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Saturates at the limit so it can never wrap back into a quiet state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy && !ready && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = busy && !ready && (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Top-level control FSM of the core: sequences fetch/decode/execute/mem/writeback,
// owns the PC, bus handshakes, writeback enable, PC redirect and sticky trap.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        rf_we,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_illegal,
  input  logic        branch_taken,
  input  logic [31:0] alu_address,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] pc_next;
  logic        bus_state;
  logic        expired;

  assign bus_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!bus_state),
    .busy   (bus_state),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    pc_next = pc_q + PC_STEP;
    if (is_jal) begin
      pc_next = alu_address;
    end else if (is_jalr) begin
      pc_next = {alu_address[31:1], 1'b0};
    end else if (is_branch && branch_taken) begin
      pc_next = alu_address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // In FETCH and MEM a ready on the limit cycle wins over the watchdog.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        if (pc_next[1:0] != 2'b00) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MISALIGNED;
        end else begin
          state_d   = ST_FETCH;
          pc_d      = pc_next;
          instret_d = instret_q + 32'd1;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: begin
        state_d = ST_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Strobes are gated by rst so an abandoned access never writes.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          ir_we    = mem_ready;
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = is_store;
          mem_addr = alu_address;
        end
        ST_WRITEBACK: rf_we = !(is_store || is_branch);
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign pc         = pc_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
